an_encoder_seq30: RTL and testbench
===================================

AN_ENCODER_SEQ30 -- requirements
Module: an_encoder_seq30

Interface
REQ-001 SHALL have parameter A, default 18613, meaning the AN code multiplier.
REQ-002 SHALL have parameter NW, default 30, meaning the data width.
REQ-003 SHALL have parameter AW, default 15, meaning the multiplier width; A < 2^AW.
REQ-004 SHALL have parameter WW, default 45 (NW+AW), meaning the codeword width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, meaning the request is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the encoder can accept a request.
REQ-009 SHALL have port N, input, NW, the data word to encode.
REQ-010 SHALL have port err_en, input, 1, meaning an arithmetic weight error is injected.
REQ-011 SHALL have port err_sign, input, 1: 0 injects +2^i, 1 injects -2^i.
REQ-012 SHALL have port err_pos, input, 6, the error bit position i.
REQ-013 SHALL have port out_valid, output, 1, meaning W is valid.
REQ-014 SHALL have port out_ready, input, 1, meaning the consumer accepts W.
REQ-015 SHALL have port W, output, WW, the codeword A*N plus the optional error.
REQ-016 SHALL have port err_dropped, output, 1, meaning the injection request was ignored because err_pos >= WW.

Function
REQ-017 SHALL implement states IDLE, MUL, ERR and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on in_valid && in_ready, SHALL latch N, err_en, err_sign and err_pos, clear the accumulator, set bit counter k=0, and go to MUL.
REQ-020 MUL: each cycle, if A[k]=1, acc SHALL become acc + (N_latched << k) modulo 2^WW; k SHALL increment; after k=AW-1 the state SHALL go to ERR (exactly AW cycles in MUL).
REQ-021 ERR (one cycle), err_en latched with err_pos < WW: W SHALL become acc + 2^err_pos (sign 0) or acc - 2^err_pos (sign 1), modulo 2^WW (two's-complement wrap, no saturation); err_dropped SHALL be 0.
REQ-022 ERR, err_en latched with err_pos >= WW: W SHALL be acc and err_dropped SHALL be 1.
REQ-023 ERR, err_en=0: W SHALL be acc and err_dropped SHALL be 0.
REQ-024 After ERR the state SHALL go to DONE with out_valid=1.
REQ-025 Latency: with the input handshake at edge 0, out_valid SHALL be 1 after edge AW+2 (edge 17 at defaults).
REQ-026 DONE: W, err_dropped and out_valid SHALL hold stable while out_ready=0.
REQ-027 DONE: on out_ready=1, out_valid SHALL fall at the next edge and the state SHALL return to IDLE; no new request is accepted in that same cycle.
REQ-028 Changes on N, err_* or in_valid outside IDLE SHALL have no effect.
REQ-029 A*N without error SHALL never overflow WW bits, since A < 2^AW; wrap occurs only via injection.

Reset
REQ-030 rst=1 SHALL immediately force state to IDLE, out_valid=0, W=0, err_dropped=0, acc=0 and k=0; in_ready SHALL be 1 while in IDLE.
REQ-031 Reset asserted mid-MUL or in DONE SHALL discard the operation; no out_valid pulse SHALL follow release.
REQ-032 After release, the first accepted request SHALL behave identically to one after power-up.

Verification
REQ-033 N=1, err_en=0, out_ready=1 -> W=18613 and err_dropped=0, with out_valid at edge 17.
REQ-034 N=1000, err_en=1, sign=0, pos=0 -> W=18613001; N=1000, sign=1, pos=3 -> W=18612992.
REQ-035 N=0, err_en=1, sign=1, pos=0 -> W=2^45-1 (wrap); N=2^30-1, err_en=0 -> W=19985556551499.
REQ-036 N=5, err_en=1, pos=50 -> W=93065 and err_dropped=1.
REQ-037 out_ready held 0 for 5 cycles in DONE -> W, out_valid and err_dropped stable, in_ready=0, a new in_valid is ignored; the transfer happens on the first cycle out_ready=1.
REQ-038 rst pulsed during MUL at k=7 -> out_valid stays 0 and in_ready=1; a following N=2 gives W=37226.

Source files
------------

// File: rtl/an_encoder_seq30.sv
// AN-code encoder: computes W = A*N by serial shift-and-add over the bits of A,
// then optionally injects a single arithmetic error of weight +/-2^err_pos.
// Valid/ready handshake on both sides; one request in flight at a time.
module an_encoder_seq30 #(
  parameter int unsigned A  = 18613,
  parameter int unsigned NW = 30,
  parameter int unsigned AW = 15,
  parameter int unsigned WW = NW + AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] N,
  input  logic          err_en,
  input  logic          err_sign,
  input  logic [5:0]    err_pos,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WW-1:0] W,
  output logic          err_dropped
);

  localparam int unsigned KW = (AW > 1) ? $clog2(AW) : 1;
  localparam logic [AW-1:0] ABits = AW'(A);
  localparam logic [KW-1:0] KLast = KW'(AW - 1);

  typedef enum logic [1:0] {StIdle, StMul, StErr, StDone} state_e;

  state_e        r_state;
  logic [NW-1:0] r_n;
  logic          r_err_en;
  logic          r_err_sign;
  logic [5:0]    r_err_pos;
  logic [WW-1:0] r_acc;
  logic [KW-1:0] r_k;
  logic [WW-1:0] r_w;
  logic          r_err_dropped;
  logic          r_out_valid;

  logic [WW-1:0] w_addend;
  logic [WW-1:0] w_err_mag;
  logic          w_pos_ok;
  logic [WW-1:0] w_w_err;

  // Partial product for the current multiplier bit and the error term
  always_comb begin
    w_addend  = WW'(r_n) << r_k;
    w_pos_ok  = (32'(r_err_pos) < WW);
    w_err_mag = WW'(1) << r_err_pos;
    // Modulo-2^WW wrap falls out of the fixed result width
    w_w_err   = r_err_sign ? (r_acc - w_err_mag) : (r_acc + w_err_mag);
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_n           <= '0;
      r_err_en      <= 1'b0;
      r_err_sign    <= 1'b0;
      r_err_pos     <= '0;
      r_acc         <= '0;
      r_k           <= '0;
      r_w           <= '0;
      r_err_dropped <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_n        <= N;
            r_err_en   <= err_en;
            r_err_sign <= err_sign;
            r_err_pos  <= err_pos;
            r_acc      <= '0;
            r_k        <= '0;
            r_state    <= StMul;
          end
        end
        StMul: begin
          if (ABits[r_k]) begin
            r_acc <= r_acc + w_addend;
          end
          r_k <= r_k + 1'b1;
          if (r_k == KLast) begin
            r_state <= StErr;
          end
        end
        StErr: begin
          if (r_err_en && w_pos_ok) begin
            r_w <= w_w_err;
          end else begin
            r_w <= r_acc;
          end
          r_err_dropped <= r_err_en && !w_pos_ok;
          r_state       <= StDone;
        end
        StDone: begin
          // Codeword is registered first; out_valid follows one cycle later
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready    = (r_state == StIdle);
  assign out_valid   = r_out_valid;
  assign W           = r_w;
  assign err_dropped = r_err_dropped;

endmodule

// File: tb/tb_an_encoder_seq30.sv
// Self-checking bench for an_encoder_seq30: directed table, hand-written
// backpressure/reset sequences, and randomized requests against a model.
module tb_an_encoder_seq30;

  localparam int unsigned A  = 18613;
  localparam int unsigned NW = 30;
  localparam int unsigned AW = 15;
  localparam int unsigned WW = 45;
  localparam int LAT = AW + 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] n;
  logic          err_en;
  logic          err_sign;
  logic [5:0]    err_pos;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] w;
  logic          err_dropped;

  int checks = 0;
  int errors = 0;

  an_encoder_seq30 #(.A(A), .NW(NW), .AW(AW), .WW(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .N           (n),
    .err_en      (err_en),
    .err_sign    (err_sign),
    .err_pos     (err_pos),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .W           (w),
    .err_dropped (err_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] n;
    logic          en;
    logic          sign;
    logic [5:0]    pos;
    logic [WW-1:0] exp_w;
    logic          exp_drop;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: integer product plus signed power-of-two error, reduced mod 2^WW
  function automatic logic [WW-1:0] model_w(input logic [NW-1:0] nn, input logic en,
                                            input logic sg, input logic [5:0] pos);
    logic [63:0] p;
    p = 64'(A) * 64'(nn);
    if (en && pos < WW) begin
      if (sg) p = p - (64'd1 << pos);
      else    p = p + (64'd1 << pos);
    end
    return p[WW-1:0];
  endfunction

  function automatic logic model_drop(input logic en, input logic [5:0] pos);
    return en && (pos >= WW);
  endfunction

  task automatic scramble();
    n        = NW'($urandom);
    err_en   = 1'($urandom);
    err_sign = 1'($urandom);
    err_pos  = 6'($urandom);
  endtask

  // Handshake a request on the next edge (edge 0), then scramble inputs
  task automatic start_req(input logic [NW-1:0] nn, input logic en, input logic sg,
                           input logic [5:0] pos, input string tag);
    chk({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
    n = nn; err_en = en; err_sign = sg; err_pos = pos;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  // Count edges after edge 0 until out_valid, bounded
  task automatic wait_valid(output int lat, output logic seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) seen = 1'b1;
      else in_valid = 1'($urandom);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_txn(input logic [NW-1:0] nn, input logic en, input logic sg,
                        input logic [5:0] pos, input int hold,
                        input logic [WW-1:0] exp_w, input logic exp_drop, input string tag);
    int   lat;
    logic seen;
    start_req(nn, en, sg, pos, tag);
    wait_valid(lat, seen);
    chk({tag, " latency"}, 64'(lat), 64'(LAT));
    chk({tag, " W"}, 64'(w), 64'(exp_w));
    chk({tag, " err_dropped"}, 64'(err_dropped), 64'(exp_drop));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      scramble();
      @(posedge clk); #1;
      chk({tag, " hold"}, {15'd0, out_valid, in_ready, err_dropped, w},
          {15'd0, 1'b1, 1'b0, exp_drop, exp_w});
    end
    // Pending in_valid must not be taken in the cycle the output transfers
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, " release"}, {62'd0, out_valid, in_ready}, 64'd1);
    @(negedge clk);
  endtask

  task automatic no_pulse(input string tag);
    int bad = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    chk({tag, " no_out_valid"}, 64'(bad), 64'd0);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 30'd1,    en: 1'b0, sign: 1'b0, pos: 6'd0,  exp_w: 45'd18613,    exp_drop: 1'b0};
    vecs[1] = '{n: 30'd1000, en: 1'b1, sign: 1'b0, pos: 6'd0,  exp_w: 45'd18613001, exp_drop: 1'b0};
    vecs[2] = '{n: 30'd1000, en: 1'b1, sign: 1'b1, pos: 6'd3,  exp_w: 45'd18612992, exp_drop: 1'b0};
    vecs[3] = '{n: 30'd0,    en: 1'b1, sign: 1'b1, pos: 6'd0,  exp_w: {45{1'b1}},   exp_drop: 1'b0};
    vecs[4] = '{n: {30{1'b1}}, en: 1'b0, sign: 1'b0, pos: 6'd0,
                exp_w: 45'd19985556551499, exp_drop: 1'b0};
    vecs[5] = '{n: 30'd5,    en: 1'b1, sign: 1'b0, pos: 6'd50, exp_w: 45'd93065,    exp_drop: 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    n = '0; err_en = 1'b0; err_sign = 1'b0; err_pos = '0;
    #1;
    chk("reset_state", {15'd0, out_valid, in_ready, err_dropped, w}, {15'd0, 1'b0, 1'b1, 1'b0, 45'd0});
    // in_valid during reset must not start anything
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {62'd0, out_valid, in_ready}, 64'd1);

    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].n, vecs[i].en, vecs[i].sign, vecs[i].pos, 0,
             vecs[i].exp_w, vecs[i].exp_drop, $sformatf("vec%0d", i));
    end

    // Backpressure: five stalled cycles in DONE
    do_txn(30'd7, 1'b1, 1'b1, 6'd44, 5, model_w(30'd7, 1'b1, 1'b1, 6'd44), 1'b0, "stall5");

    // Reset mid-MUL at k=7
    start_req(30'd9, 1'b0, 1'b0, 6'd0, "rst_mul");
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mul async", {15'd0, out_valid, in_ready, err_dropped, w}, {15'd0, 1'b0, 1'b1, 1'b0, 45'd0});
    @(negedge clk);
    rst = 1'b0;
    no_pulse("rst_mul");
    do_txn(30'd2, 1'b0, 1'b0, 6'd0, 0, 45'd37226, 1'b0, "after_rst");

    // Reset while holding a result in DONE
    start_req(30'd11, 1'b1, 1'b0, 6'd60, "rst_done");
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("rst_done valid_before", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_done async", {15'd0, out_valid, in_ready, err_dropped, w}, {15'd0, 1'b0, 1'b1, 1'b0, 45'd0});
    @(negedge clk);
    rst = 1'b0;
    no_pulse("rst_done");

    // Randomized requests against the model
    for (int i = 0; i < 24; i++) begin
      logic [NW-1:0] rn;
      logic          ren, rsg;
      logic [5:0]    rpos;
      rn   = NW'($urandom);
      if (i % 4 == 0) rn = {NW{1'b1}};
      ren  = 1'($urandom);
      rsg  = 1'($urandom);
      rpos = 6'($urandom_range(0, 63));
      do_txn(rn, ren, rsg, rpos, int'($urandom_range(0, 3)),
             model_w(rn, ren, rsg, rpos), model_drop(ren, rpos), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
